mips_datapath: RTL and testbench

- 8-bit-wide multicycle MIPS datapath (TinyMIPS), driven cycle-by-cycle by an external controller; no internal FSM.
- Holds PC, byte-loaded 32-bit instruction register, memory data register (MDR), register file, A/B operand registers, ALU and ALUOut register.
- Generates the memory address, memory write data and the ALU zero flag.

---
 rtl/mips_datapath_pkg.sv | 24 ++
 rtl/mips_regfile.sv | 30 +++
 rtl/mips_datapath.sv | 136 +++++++++++++
 tb/tb_mips_datapath.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mips_datapath_pkg.sv
// Shared encodings for the TinyMIPS multicycle datapath: ALU operations and
// the select codes of the ALU B-operand and next-PC multiplexers.
package mips_datapath_pkg;

  // ALU operation codes; codes not listed produce a zero result
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_ZERO   = 2'b11;

endpackage

// File: rtl/mips_regfile.sv
// Register file: two combinational read ports, one synchronous write port.
// Register 0 is hard-wired to zero; its storage is never written.
module mips_regfile #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3
) (
  input  logic               clk,
  input  logic               regwrite,
  input  logic [REGBITS-1:0] ra1,
  input  logic [REGBITS-1:0] ra2,
  input  logic [REGBITS-1:0] wa,
  input  logic [WIDTH-1:0]   wd,
  output logic [WIDTH-1:0]   rd1,
  output logic [WIDTH-1:0]   rd2
);

  logic [WIDTH-1:0] mem_r [0:(2**REGBITS)-1];

  // Synchronous write; writes addressed to register 0 are dropped
  always_ff @(posedge clk) begin
    if (regwrite && (wa != {REGBITS{1'b0}})) begin
      mem_r[wa] <= wd;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write returns the old value
  assign rd1 = (ra1 == {REGBITS{1'b0}}) ? {WIDTH{1'b0}} : mem_r[ra1];
  assign rd2 = (ra2 == {REGBITS{1'b0}}) ? {WIDTH{1'b0}} : mem_r[ra2];

endmodule

// File: rtl/mips_datapath.sv
// TinyMIPS multicycle datapath. All sequencing comes from an external
// controller; this block only holds state, muxes operands and runs the ALU.
module mips_datapath
  import mips_datapath_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             const_gnd,
  input  logic [WIDTH-1:0] memdata,
  input  logic             alusrca,
  input  logic [1:0]       alusrcb,
  input  logic             iord,
  input  logic [3:0]       irwrite,
  input  logic             memtoreg,
  input  logic             pcen,
  input  logic             regdst,
  input  logic             regwrite,
  input  logic [1:0]       pcsource,
  input  logic [2:0]       alucont,
  output logic             zero,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata
);

  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]   pc_r, mdr_r, a_r, b_r, aluout_r;
  logic [31:0]        instr_r;
  logic [WIDTH-1:0]   rd1_s, rd2_s, wd_s;
  logic [REGBITS-1:0] wa_s;
  logic [WIDTH-1:0]   srca_s, srcb_s, diff_s, alu_s, nextpc_s;
  logic [WIDTH-1:0]   zero_w_s;

  // Zero word built from the board's ground pin
  assign zero_w_s = {WIDTH{const_gnd}};

  // Register file: rs/rt read, rt or rd write, ALUOut or MDR write data
  assign wa_s = regdst ? instr_r[11+REGBITS-1:11] : instr_r[16+REGBITS-1:16];
  assign wd_s = memtoreg ? mdr_r : aluout_r;

  mips_regfile #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_rf (
    .clk      (clk),
    .regwrite (regwrite),
    .ra1      (instr_r[21+REGBITS-1:21]),
    .ra2      (instr_r[16+REGBITS-1:16]),
    .wa       (wa_s),
    .wd       (wd_s),
    .rd1      (rd1_s),
    .rd2      (rd2_s)
  );

  // ALU operand selection
  always_comb begin
    srca_s = alusrca ? a_r : pc_r;
    srcb_s = b_r;
    case (alusrcb)
      SRCB_B:     srcb_s = b_r;
      SRCB_ONE:   srcb_s = ONE_W;
      SRCB_IMM:   srcb_s = instr_r[WIDTH-1:0];
      SRCB_IMMSH: srcb_s = {instr_r[WIDTH-3:0], const_gnd, const_gnd};
      default:    srcb_s = b_r;
    endcase
  end

  // ALU: wrap-around arithmetic, SLT taken from the sign of a-b
  always_comb begin
    diff_s = srca_s - srcb_s;
    alu_s  = {WIDTH{1'b0}};
    case (alucont)
      ALU_AND: alu_s = srca_s & srcb_s;
      ALU_OR:  alu_s = srca_s | srcb_s;
      ALU_ADD: alu_s = srca_s + srcb_s;
      ALU_SUB: alu_s = diff_s;
      ALU_SLT: alu_s = diff_s[WIDTH-1] ? ONE_W : {WIDTH{1'b0}};
      default: alu_s = {WIDTH{1'b0}};
    endcase
  end

  // Next-PC selection
  always_comb begin
    nextpc_s = alu_s;
    case (pcsource)
      PCSRC_ALU:    nextpc_s = alu_s;
      PCSRC_ALUOUT: nextpc_s = aluout_r;
      PCSRC_JUMP:   nextpc_s = {instr_r[WIDTH-3:0], const_gnd, const_gnd};
      PCSRC_ZERO:   nextpc_s = zero_w_s;
      default:      nextpc_s = alu_s;
    endcase
  end

  // Program counter, loaded only when the controller enables it
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r <= {WIDTH{1'b0}};
    end else if (pcen) begin
      pc_r <= nextpc_s;
    end
  end

  // Instruction register: each byte lane captures memdata on its own enable
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_r <= 32'h0000_0000;
    end else begin
      if (irwrite[0]) instr_r[31:24] <= memdata;
      if (irwrite[1]) instr_r[23:16] <= memdata;
      if (irwrite[2]) instr_r[15:8]  <= memdata;
      if (irwrite[3]) instr_r[7:0]   <= memdata;
    end
  end

  // Free-running pipeline registers: MDR, A, B and ALUOut load every cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      mdr_r    <= {WIDTH{1'b0}};
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      aluout_r <= {WIDTH{1'b0}};
    end else begin
      mdr_r    <= memdata;
      a_r      <= rd1_s;
      b_r      <= rd2_s;
      aluout_r <= alu_s;
    end
  end

  assign zero      = (alu_s == {WIDTH{1'b0}});
  assign instr     = instr_r;
  assign adr       = iord ? aluout_r : pc_r;
  assign writedata = b_r;

endmodule

// File: tb/tb_mips_datapath.sv
// Directed bench for the TinyMIPS datapath: the bench plays the controller
// and checks hand-computed values after each rising edge.
module tb_mips_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        const_gnd;
  logic [7:0]  memdata;
  logic        alusrca;
  logic [1:0]  alusrcb;
  logic        iord;
  logic [3:0]  irwrite;
  logic        memtoreg;
  logic        pcen;
  logic        regdst;
  logic        regwrite;
  logic [1:0]  pcsource;
  logic [2:0]  alucont;
  logic        zero;
  logic [31:0] instr;
  logic [7:0]  adr;
  logic [7:0]  writedata;

  int checks = 0;
  int errors = 0;

  mips_datapath #(.WIDTH(8), .REGBITS(3)) dut (
    .clk(clk), .reset(reset), .const_gnd(const_gnd), .memdata(memdata),
    .alusrca(alusrca), .alusrcb(alusrcb), .iord(iord), .irwrite(irwrite),
    .memtoreg(memtoreg), .pcen(pcen), .regdst(regdst), .regwrite(regwrite),
    .pcsource(pcsource), .alucont(alucont), .zero(zero), .instr(instr),
    .adr(adr), .writedata(writedata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write one byte into the rt lane (instr[23:16]) of the IR
  task automatic load_lane1(input logic [7:0] b);
    irwrite = 4'b0010; memdata = b; step(); irwrite = 4'b0000;
  endtask

  // Write MDR-sourced value into register rt (rt must already be in IR)
  task automatic write_rt(input logic [7:0] v);
    memdata = v; step();
    memtoreg = 1'b1; regdst = 1'b0; regwrite = 1'b1; step();
    regwrite = 1'b0; memtoreg = 1'b0;
  endtask

  initial begin
    reset = 1'b0; const_gnd = 1'b0; memdata = 8'h00;
    alusrca = 1'b0; alusrcb = 2'b00; iord = 1'b0; irwrite = 4'b0000;
    memtoreg = 1'b0; pcen = 1'b0; regdst = 1'b0; regwrite = 1'b0;
    pcsource = 2'b00; alucont = 3'b000;

    // Reset state
    step(); step();
    chk("rst_instr", instr, 32'h0000_0000);
    chk("rst_adr", {24'h0, adr}, 32'h0000_0000);
    chk("rst_wd", {24'h0, writedata}, 32'h0000_0000);
    chk("rst_zero", {31'h0, zero}, 32'h0000_0001);
    reset = 1'b1;

    // IR byte-lane loading
    irwrite = 4'b0001; memdata = 8'h00; step();
    chk("ir_b0", instr, 32'h0000_0000);
    irwrite = 4'b0010; memdata = 8'h43; step();
    chk("ir_b1", instr, 32'h0043_0000);
    irwrite = 4'b0100; memdata = 8'h08; step();
    chk("ir_b2", instr, 32'h0043_0800);
    irwrite = 4'b1000; memdata = 8'h20; step();
    chk("ir_b3", instr, 32'h0043_0820);
    irwrite = 4'b0000; memdata = 8'hFF; step();
    chk("ir_hold", instr, 32'h0043_0820);

    // PC increments by one three times
    alusrca = 1'b0; alusrcb = 2'b01; alucont = 3'b010; pcsource = 2'b00; pcen = 1'b1;
    step(); step(); step();
    chk("pc_inc3", {24'h0, adr}, 32'h0000_0003);
    pcen = 1'b0;

    // Jump: instr[5:0]=000101 -> 0x14
    irwrite = 4'b1000; memdata = 8'h05; step(); irwrite = 4'b0000;
    chk("ir_low05", instr, 32'h0043_0805);
    pcsource = 2'b10; pcen = 1'b1; step(); pcen = 1'b0;
    chk("pc_jump", {24'h0, adr}, 32'h0000_0014);

    // PC = 0x14 + 0xEB = 0xFF, then wrap to 0x00
    irwrite = 4'b1000; memdata = 8'hEB; step(); irwrite = 4'b0000;
    alusrcb = 2'b10; pcsource = 2'b00; pcen = 1'b1; step();
    chk("pc_ff", {24'h0, adr}, 32'h0000_00FF);
    alusrcb = 2'b01; step(); pcen = 1'b0;
    chk("pc_wrap", {24'h0, adr}, 32'h0000_0000);

    // PC from ALUOut (0 + 0xEB), then the all-zero source
    alusrcb = 2'b10; step();
    pcsource = 2'b01; pcen = 1'b1; step();
    chk("pc_aluout", {24'h0, adr}, 32'h0000_00EB);
    pcsource = 2'b11; step(); pcen = 1'b0;
    chk("pc_zero", {24'h0, adr}, 32'h0000_0000);

    // Reset mid-operation with enables active
    alusrcb = 2'b01; pcsource = 2'b00; pcen = 1'b1;
    step(); step(); step(); step(); step();
    chk("pc_5", {24'h0, adr}, 32'h0000_0005);
    reset = 1'b0; irwrite = 4'b1111; memdata = 8'hAA; step();
    chk("mid_rst_pc", {24'h0, adr}, 32'h0000_0000);
    chk("mid_rst_instr", instr, 32'h0000_0000);
    chk("mid_rst_wd", {24'h0, writedata}, 32'h0000_0000);
    iord = 1'b1; #1;
    chk("mid_rst_aluout", {24'h0, adr}, 32'h0000_0000);
    iord = 1'b0; reset = 1'b1; irwrite = 4'b0000; pcen = 1'b0;

    // Register writes through MDR: r2=5, r3=7, r0 stays 0
    load_lane1(8'h42); write_rt(8'h05); step();
    chk("r2_5", {24'h0, writedata}, 32'h0000_0005);
    load_lane1(8'h43); write_rt(8'h07); step();
    chk("r3_7", {24'h0, writedata}, 32'h0000_0007);
    load_lane1(8'h40); write_rt(8'h09); step();
    chk("r0_zero", {24'h0, writedata}, 32'h0000_0000);

    // Same-edge write/read of r2 returns the old value
    load_lane1(8'h42); write_rt(8'h06);
    chk("r2_old", {24'h0, writedata}, 32'h0000_0005);
    step();
    chk("r2_new", {24'h0, writedata}, 32'h0000_0006);
    write_rt(8'h05);

    // ADD flow: rs=2 (5), rt=3 (7), rd=1
    load_lane1(8'h43);
    irwrite = 4'b0100; memdata = 8'h08; step();
    irwrite = 4'b1000; memdata = 8'h20; step(); irwrite = 4'b0000;
    chk("ir_add", instr, 32'h0043_0820);
    step();
    chk("add_b", {24'h0, writedata}, 32'h0000_0007);
    alusrca = 1'b1; alusrcb = 2'b00; alucont = 3'b010; #1;
    chk("add_zero", {31'h0, zero}, 32'h0000_0000);
    step(); iord = 1'b1; #1;
    chk("add_aluout", {24'h0, adr}, 32'h0000_000C);
    memtoreg = 1'b0; regdst = 1'b1; regwrite = 1'b1; step();
    regwrite = 1'b0; regdst = 1'b0;
    load_lane1(8'h41); step();
    chk("r1_12", {24'h0, writedata}, 32'h0000_000C);

    // ALU with A=5, B=5
    load_lane1(8'h42); step();
    alucont = 3'b110; #1;
    chk("sub55_zero", {31'h0, zero}, 32'h0000_0001);
    step();
    chk("sub55", {24'h0, adr}, 32'h0000_0000);
    alucont = 3'b111; #1;
    chk("slt55_zero", {31'h0, zero}, 32'h0000_0001);
    step();
    chk("slt55", {24'h0, adr}, 32'h0000_0000);
    alucont = 3'b010; step();
    chk("add55", {24'h0, adr}, 32'h0000_000A);

    // ALU with A=3 (r4), B=5 (r2)
    load_lane1(8'h44); write_rt(8'h03);
    load_lane1(8'h82); step();
    alucont = 3'b111; #1;
    chk("slt35_zero", {31'h0, zero}, 32'h0000_0000);
    step();
    chk("slt35", {24'h0, adr}, 32'h0000_0001);
    alucont = 3'b000; step();
    chk("and35", {24'h0, adr}, 32'h0000_0001);
    alucont = 3'b001; step();
    chk("or35", {24'h0, adr}, 32'h0000_0007);
    alucont = 3'b110; step();
    chk("sub35", {24'h0, adr}, 32'h0000_00FE);
    alucont = 3'b011; #1;
    chk("op011_zero", {31'h0, zero}, 32'h0000_0001);
    step();
    chk("op011", {24'h0, adr}, 32'h0000_0000);

    // Shifted immediate: instr[5:0]=100000 -> 0x80, 3 + 0x80
    alucont = 3'b010; alusrcb = 2'b11; step();
    chk("immsh", {24'h0, adr}, 32'h0000_0083);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
